fpall_arbiter: RTL
==================

FPALL_ARBITER -- requirements
Module: fpall_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one fpall_shared instance (2..8).
REQ-002 Parameter: LAT, 3, cycles from operands presented on fpu_* to fpu_r valid (1..8).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  input  N_REQ  per-requester operation request.
REQ-006 Port: req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port: req_opcode  input  N_REQ x 2  fp_op_e per requester (00 add, 01 mul, 10 sqrt, 11 div).
REQ-008 Port: req_fmt  input  N_REQ x 1  fp_fmt_e per requester (0 FP32, 1 FP16).
REQ-009 Port: req_x, req_y  input  N_REQ x 32 each  operands per requester.
REQ-010 Port: fpu_opcode, fpu_fmt, fpu_x, fpu_y  output  2/1/32/32  operands to shared unit.
REQ-011 Port: fpu_r  input  32  result from shared unit.
REQ-012 Port: rsp_valid, rsp_ready  output/input  1/1  response handshake.
REQ-013 Port: rsp_id, rsp_r  output  clog2(N_REQ)/32  originating requester index and result.
REQ-014 Port: perf_issue, perf_stall  output  32/32  performance counters (see Configuration).

Function
REQ-015 Issue in cycle t: req_valid[i] & req_ready[i]; fpu_* driven combinationally from requester i in cycle t; fpu_* hold last issued values when no issue.
REQ-016 Arbitration: round-robin; search starts at index (last_grant+1) mod N_REQ; last_grant updates only on issue.
REQ-017 Credits: response FIFO depth D = LAT+2; credit counter starts at D, decrements on issue, increments on FIFO pop; simultaneous issue and pop leave it unchanged.
REQ-018 req_ready[i] high only if i is round-robin winner among valid requesters and credits > 0; req_ready independent of req_valid of non-winners.
REQ-019 Tag pipe: LAT-stage shift register of {valid, id}; issue at t loads stage 0; stage LAT-1 at end of cycle t+LAT-1 writes {id, fpu_r} into FIFO.
REQ-020 Latency: issue at t gives earliest rsp_valid in cycle t+LAT (FIFO non-fall-through, registered output); responses in issue order.
REQ-021 FIFO pop on rsp_valid & rsp_ready; rsp_id/rsp_r stable while rsp_valid & !rsp_ready.
REQ-022 FIFO overflow impossible by credit rule; empty FIFO gives rsp_valid=0.
REQ-023 Back-to-back issue every cycle sustained when rsp_ready held high.
REQ-024 Pointers, FIFO count and credit counter wrap modulo their widths; no other wrap.

Reset
REQ-025 On rst_n low (asynchronous): req_ready=0, rsp_valid=0, rsp_id=0, rsp_r=0, fpu_*=0, last_grant=N_REQ-1, credits=D, tag pipe valid bits=0, FIFO empty, perf counters=0.
REQ-026 Reset mid-operation discards all in-flight and queued results; no response after reset release for pre-reset issues.
REQ-027 First cycle after release: requester 0 has highest priority.

Configuration
REQ-028 Macro FPALL_ARB_PERF_EN defined: perf_issue increments per issue; perf_stall increments per cycle with any req_valid and no issue; both saturate at 0xFFFFFFFF.
REQ-029 Macro undefined: perf_issue and perf_stall tied to 0, no counter flops.

Structure
REQ-030 fp_op_e, fp_fmt_e reused from fpall_pkg; add FPALL_ARB_MAX_REQ=8 and typedef fpall_arb_rsp_t {id, r} there.
REQ-031 One sub-module: fpall_arb_rsp_fifo (parameter depth, fpall_arb_rsp_t payload, valid/ready pop, push enable).

Verification
REQ-032 N_REQ=4, LAT=3; req 0 add FP32 X=0x3F800000 Y=0x40000000 at t -> rsp_valid at t+3, rsp_id=0, rsp_r=0x40400000.
REQ-033 All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, mul 0x40000000*0x40400000 returns 0x40C00000 tagged correctly.
REQ-034 rsp_ready=0, req 1 valid continuously -> exactly 5 issues, then req_ready=0; one pop -> one further issue.
REQ-035 Issue 3 ops then rst_n low 1 cycle mid-flight -> no rsp_valid for 10 cycles after release; credits=5.
REQ-036 FPALL_ARB_PERF_EN defined, 10 cycles with 1 issue blocked by zero credits for 4 -> perf_issue and perf_stall match counts; undefined -> both read 0.

Source files
------------

// File: rtl/fpall_pkg.sv
// Shared FPU types plus the arbiter's response payload.
// Imported by fpall_arbiter and fpall_arb_rsp_fifo.
package fpall_pkg;

    typedef enum logic [1:0] {
        FP_ADD  = 2'b00,
        FP_MUL  = 2'b01,
        FP_SQRT = 2'b10,
        FP_DIV  = 2'b11
    } fp_op_e;

    typedef enum logic {
        FP_FMT_FP32 = 1'b0,
        FP_FMT_FP16 = 1'b1
    } fp_fmt_e;

    localparam int FPALL_ARB_MAX_REQ = 8;
    localparam int FPALL_ARB_ID_W    = $clog2(FPALL_ARB_MAX_REQ);

    // The id field is sized for the largest supported requester count.
    typedef struct packed {
        logic [FPALL_ARB_ID_W-1:0] id;
        logic [31:0]               r;
    } fpall_arb_rsp_t;

endpackage

// File: rtl/fpall_arb_rsp_fifo.sv
// Response FIFO for fpall_arbiter: push enable in, valid/ready pop out.
// Output is zero whenever the FIFO is empty.
module fpall_arb_rsp_fifo
    import fpall_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_en,
    input  fpall_arb_rsp_t push_data,
    output logic           pop_valid,
    input  logic           pop_ready,
    output fpall_arb_rsp_t pop_data
);

    // Storage is rounded up to a power of two so the pointers wrap naturally;
    // the credit scheme upstream never lets more than DEPTH entries in.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fpall_arb_rsp_t    mem [2**AW];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              pop;

    assign pop       = pop_valid & pop_ready;
    assign pop_valid = (count != '0);
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fpall_arbiter.sv
// Round-robin, credit-flow-controlled front end sharing one fpall_shared unit.
// Define FPALL_ARB_PERF_EN to build the saturating perf_issue/perf_stall counters.
module fpall_arbiter
    import fpall_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LAT   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0][1:0]    req_opcode,
    input  logic [N_REQ-1:0]         req_fmt,
    input  logic [N_REQ-1:0][31:0]   req_x,
    input  logic [N_REQ-1:0][31:0]   req_y,
    output fp_op_e                   fpu_opcode,
    output fp_fmt_e                  fpu_fmt,
    output logic [31:0]              fpu_x,
    output logic [31:0]              fpu_y,
    input  logic [31:0]              fpu_r,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_r,
    output logic [31:0]              perf_issue,
    output logic [31:0]              perf_stall
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int D    = LAT + 2;
    localparam int CW   = $clog2(D + 1);

    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic            found;
    int              idx;
    logic [CW-1:0]   credits;
    logic            issue;
    logic            pop;

    fp_op_e          held_op;
    fp_fmt_e         held_fmt;
    logic [31:0]     held_x;
    logic [31:0]     held_y;

    logic            push_valid;
    logic [ID_W-1:0] push_id;
    fpall_arb_rsp_t  push_data;
    fpall_arb_rsp_t  rsp_data;

    // First valid requester at or after last_grant+1, wrapping around.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Reset is also folded in here so req_ready stays low while rst_n is held.
    assign issue = rst_n && found && (credits != '0);
    assign pop   = rsp_valid & rsp_ready;

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[winner] = 1'b1;
    end

    assign fpu_opcode = issue ? fp_op_e'(req_opcode[winner]) : held_op;
    assign fpu_fmt    = issue ? fp_fmt_e'(req_fmt[winner])   : held_fmt;
    assign fpu_x      = issue ? req_x[winner]                : held_x;
    assign fpu_y      = issue ? req_y[winner]                : held_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(N_REQ - 1);
            credits    <= CW'(D);
            held_op    <= FP_ADD;
            held_fmt   <= FP_FMT_FP32;
            held_x     <= '0;
            held_y     <= '0;
        end else begin
            if (issue) begin
                last_grant <= winner;
                held_op    <= fp_op_e'(req_opcode[winner]);
                held_fmt   <= fp_fmt_e'(req_fmt[winner]);
                held_x     <= req_x[winner];
                held_y     <= req_y[winner];
            end
            case ({issue, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: ;
            endcase
        end
    end

    // Stage 0 of the tag pipe is the issue cycle itself; the remaining LAT-1
    // stages are flops, so the last one lines up with fpu_r for that issue.
    generate
        if (LAT == 1) begin : g_no_pipe
            assign push_valid = issue;
            assign push_id    = winner;
        end else begin : g_pipe
            logic [LAT-2:0]           tag_v;
            logic [LAT-2:0][ID_W-1:0] tag_id;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_v  <= '0;
                    tag_id <= '0;
                end else begin
                    tag_v[0]  <= issue;
                    tag_id[0] <= winner;
                    for (int s = 1; s < LAT - 1; s++) begin
                        tag_v[s]  <= tag_v[s-1];
                        tag_id[s] <= tag_id[s-1];
                    end
                end
            end

            assign push_valid = tag_v[LAT-2];
            assign push_id    = tag_id[LAT-2];
        end
    endgenerate

    assign push_data = '{id: FPALL_ARB_ID_W'(push_id), r: fpu_r};

    fpall_arb_rsp_fifo #(
        .DEPTH (D)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_en   (push_valid),
        .push_data (push_data),
        .pop_valid (rsp_valid),
        .pop_ready (rsp_ready),
        .pop_data  (rsp_data)
    );

    assign rsp_id = ID_W'(rsp_data.id);
    assign rsp_r  = rsp_data.r;

`ifdef FPALL_ARB_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue && (perf_issue_q != '1))
                perf_issue_q <= perf_issue_q + 32'd1;
            if ((|req_valid) && !issue && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_issue = '0;
    assign perf_stall = '0;
`endif

endmodule
